// File: rtl/pic_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pic_bus_pkg                                            |
// | Description : Shared types and helpers for the 8259A host initiator  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package pic_bus_pkg;

   typedef enum logic [1:0] {
      CMD_INIT  = 2'd0,
      CMD_WRITE = 2'd1,
      CMD_READ  = 2'd2
   } cmd_kind_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_GAP    = 3'd4,
      ST_ERR    = 3'd5
   } state_e;

   localparam int ICW1_IC4  = 0;
   localparam int ICW1_SNGL = 1;

   // Next ICW index after idx as {more, index}; more=0 ends the INIT sequence
   function automatic logic [2:0] next_icw(input logic [1:0] idx,
                                           input logic       sngl,
                                           input logic       ic4);
      logic [2:0] nxt;
      nxt = 3'b000;
      case (idx)
         2'd0: nxt = {1'b1, 2'd1};
         2'd1: begin
            if (!sngl)
               nxt = {1'b1, 2'd2};
            else if (ic4)
               nxt = {1'b1, 2'd3};
         end
         2'd2: begin
            if (ic4)
               nxt = {1'b1, 2'd3};
         end
         default: nxt = 3'b000;
      endcase
      return nxt;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pic_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pic_phase_timer                                        |
// | Description : Loadable down-counter timing the bus cycle phases      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pic_phase_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] r_cnt;

   // Reload on phase entry, then count down and park at 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (load)
         r_cnt <= load_val;
      else if (r_cnt > CNT_W'(1))
         r_cnt <= r_cnt - CNT_W'(1);
   end

   assign done = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/pic_host_bus_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pic_host_bus_initiator                                 |
// | Description : Command-driven host bus master for the 8259A PIC       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pic_host_bus_initiator
   import pic_bus_pkg::*;
#(
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_kind,
   input  logic        cmd_a0,
   input  logic [7:0]  cmd_data,
   input  logic [31:0] init_words,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        err,
   output logic        init_done,
   output logic        cs_n,
   output logic        wr_n,
   output logic        rd_n,
   output logic        a0,
   output logic [7:0]  dout,
   output logic        dout_en,
   input  logic [7:0]  din
);

   localparam int c_max_cyc = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
   localparam int c_cnt_w   = $clog2(c_max_cyc + 1);
   localparam logic [c_cnt_w-1:0] c_setup_ld = c_cnt_w'(SETUP_CYC);
   localparam logic [c_cnt_w-1:0] c_pulse_ld = c_cnt_w'(PULSE_CYC);
   localparam logic [c_cnt_w-1:0] c_hold_ld  = c_cnt_w'(HOLD_CYC);

   state_e              r_state, w_state_d;
   logic [1:0]          r_idx, w_idx_d;
   logic [31:0]         r_words, w_words_d;
   logic                r_is_write, w_is_write_d;
   logic                r_is_init, w_is_init_d;
   logic                w_a0_d, w_err_d, w_rsp_d, w_done_d;
   logic [7:0]          w_dout_d;
   logic                w_ld, w_tmr_done, w_more, w_init_ok, w_active_d;
   logic [c_cnt_w-1:0]  w_ld_val;
   logic [2:0]          w_nxt;
   cmd_kind_e           w_kind;

   pic_phase_timer #(.CNT_W(c_cnt_w)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_ld),
      .load_val (w_ld_val),
      .done     (w_tmr_done)
   );

   assign w_kind    = cmd_kind_e'(cmd_kind);
   assign w_nxt     = next_icw(r_idx, r_words[ICW1_SNGL], r_words[ICW1_IC4]);
   assign w_more    = r_is_init & w_nxt[2];
   // The final GAP of an INIT already counts as initialized for a command taken in it
   assign w_init_ok = init_done | ((r_state == ST_GAP) & r_is_init);

   // Next-state, phase timer loads and next values of the registered outputs
   always_comb begin
      w_state_d    = r_state;
      w_idx_d      = r_idx;
      w_words_d    = r_words;
      w_is_write_d = r_is_write;
      w_is_init_d  = r_is_init;
      w_a0_d       = a0;
      w_dout_d     = dout;
      w_err_d      = 1'b0;
      w_rsp_d      = 1'b0;
      w_done_d     = init_done;
      w_ld         = 1'b0;
      w_ld_val     = c_setup_ld;
      case (r_state)
         // The last GAP of a transfer doubles as an idle cycle so that
         // back-to-back commands leave cs_n high for a single cycle.
         ST_IDLE, ST_GAP: begin
            if ((r_state == ST_GAP) && w_more) begin
               w_state_d = ST_SETUP;
               w_ld      = 1'b1;
               w_idx_d   = w_nxt[1:0];
               w_a0_d    = 1'b1;
               w_dout_d  = r_words[{w_nxt[1:0], 3'b000} +: 8];
            end else begin
               w_state_d = ST_IDLE;
               if ((r_state == ST_GAP) && r_is_init)
                  w_done_d = 1'b1;
               if (cmd_valid) begin
                  case (w_kind)
                     CMD_INIT: begin
                        w_words_d    = init_words;
                        w_done_d     = 1'b0;
                        w_is_init_d  = 1'b1;
                        w_is_write_d = 1'b1;
                        w_idx_d      = 2'd0;
                        w_a0_d       = 1'b0;
                        w_dout_d     = init_words[7:0];
                        w_state_d    = ST_SETUP;
                        w_ld         = 1'b1;
                     end
                     CMD_WRITE, CMD_READ: begin
                        if (w_init_ok) begin
                           w_is_init_d  = 1'b0;
                           w_is_write_d = (w_kind == CMD_WRITE);
                           w_a0_d       = cmd_a0;
                           if (w_kind == CMD_WRITE)
                              w_dout_d = cmd_data;
                           w_state_d    = ST_SETUP;
                           w_ld         = 1'b1;
                        end else begin
                           w_state_d = ST_ERR;
                           w_err_d   = 1'b1;
                        end
                     end
                     default: begin
                        w_state_d = ST_ERR;
                        w_err_d   = 1'b1;
                     end
                  endcase
               end
            end
         end
         ST_SETUP: begin
            if (w_tmr_done) begin
               w_state_d = ST_STROBE;
               w_ld      = 1'b1;
               w_ld_val  = c_pulse_ld;
            end
         end
         ST_STROBE: begin
            if (w_tmr_done) begin
               w_state_d = ST_HOLD;
               w_ld      = 1'b1;
               w_ld_val  = c_hold_ld;
            end
         end
         ST_HOLD: begin
            if (w_tmr_done) begin
               w_state_d = ST_GAP;
               w_rsp_d   = ~r_is_write;
            end
         end
         ST_ERR:  w_state_d = ST_IDLE;
         default: w_state_d = ST_IDLE;
      endcase
   end

   assign w_active_d = (w_state_d == ST_SETUP) || (w_state_d == ST_STROBE) ||
                       (w_state_d == ST_HOLD);

   // State register and registered bus pins; reset forces the bus idle at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_idx      <= 2'd0;
         r_words    <= 32'd0;
         r_is_write <= 1'b0;
         r_is_init  <= 1'b0;
         cmd_ready  <= 1'b1;
         cs_n       <= 1'b1;
         wr_n       <= 1'b1;
         rd_n       <= 1'b1;
         a0         <= 1'b0;
         dout       <= 8'd0;
         dout_en    <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= 8'd0;
         err        <= 1'b0;
         init_done  <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_idx      <= w_idx_d;
         r_words    <= w_words_d;
         r_is_write <= w_is_write_d;
         r_is_init  <= w_is_init_d;
         cmd_ready  <= (w_state_d == ST_IDLE) || ((w_state_d == ST_GAP) && !w_more);
         cs_n       <= ~w_active_d;
         wr_n       <= ~((w_state_d == ST_STROBE) && w_is_write_d);
         rd_n       <= ~((w_state_d == ST_STROBE) && !w_is_write_d);
         a0         <= w_a0_d;
         dout       <= w_dout_d;
         dout_en    <= w_active_d && w_is_write_d;
         rsp_valid  <= w_rsp_d;
         err        <= w_err_d;
         init_done  <= w_done_d;
         if ((r_state == ST_STROBE) && w_tmr_done && !r_is_write)
            rsp_data <= din;
      end
   end

endmodule
`default_nettype wire
